// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for a 5-stage pipeline; HAZARD_FWD_EN selects load-use-only hazards
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic        ex_regwrite,
  input  logic        mem_regwrite,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t state, state_nx;
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic use_rs1, use_rs2, hit_rs1, hit_rs2, hazard;
  logic pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c;
  assign op      = id_instr[6:0];
  assign rs1     = id_instr[19:15];
  assign rs2     = id_instr[24:20];
  assign use_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign use_rs1 = use_rs2 || (op inside {7'b0000011, 7'b0010011, 7'b1100111});
`ifdef HAZARD_FWD_EN
  // forwarding covers everything except a load feeding the very next instruction
  assign hit_rs1 = ex_memread && ex_regwrite && ex_rd == rs1;
  assign hit_rs2 = ex_memread && ex_regwrite && ex_rd == rs2;
`else
  // no forwarding: wait until producers in EX and MEM have reached WB
  assign hit_rs1 = (ex_regwrite && ex_rd == rs1) || (mem_regwrite && mem_rd == rs1);
  assign hit_rs2 = (ex_regwrite && ex_rd == rs2) || (mem_regwrite && mem_rd == rs2);
`endif
  assign hazard = id_valid && state != FLUSH &&
                  ((use_rs1 && rs1 != 5'd0 && hit_rs1) || (use_rs2 && rs2 != 5'd0 && hit_rs2));
  // next state and Mealy controls; a redirect overrides any hazard
  always_comb begin
    state_nx      = ex_redirect ? FLUSH : hazard ? STALL : RUN;
    pc_stall_c    = !ex_redirect && hazard;
    ifid_stall_c  = !ex_redirect && hazard;
    idex_bubble_c = ex_redirect || hazard;
    ifid_flush_c  = ex_redirect;
  end
  // controls are forced low asynchronously while reset is held
  assign pc_stall    = rst_n & pc_stall_c;
  assign ifid_stall  = rst_n & ifid_stall_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign ctrl_state  = state;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  // saturating performance counters, clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 16'd1;
      if (ifid_flush && !(&flush_count)) flush_count <= flush_count + 16'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (honours HAZARD_FWD_EN)
module tb_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] ADD  = 32'h006283B3;
  localparam logic [31:0] ADDI = 32'h00128093;
  localparam logic [31:0] LUI  = 32'h000282B7;
  localparam logic [31:0] ADX0 = 32'h00100093;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] id_instr = '0;
  logic id_valid = 1'b0, ex_regwrite = 1'b0, mem_regwrite = 1'b0, ex_memread = 1'b0;
  logic ex_redirect = 1'b0, cnt_clr = 1'b0;
  logic [4:0] ex_rd = '0, mem_rd = '0;
  logic pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [1:0] ctrl_state;
  logic [15:0] stall_cycles, flush_count;
  int n_assert = 0, n_fail = 0;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
    .ex_memread(ex_memread), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_assert++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic drv(input logic [31:0] ins, input logic v, input logic [4:0] erd,
                     input logic erw, input logic emr, input logic [4:0] mrd,
                     input logic mrw, input logic rd, input logic clr);
    id_instr = ins; id_valid = v; ex_rd = erd; ex_regwrite = erw; ex_memread = emr;
    mem_rd = mrd; mem_regwrite = mrw; ex_redirect = rd; cnt_clr = clr;
  endtask

  // called at a negedge with inputs driven: checks Mealy controls and current state, then advances one cycle
  task automatic step(input string tag, input logic [3:0] c, input logic [1:0] s);
    push({tag, "_ctrl"}, {28'd0, c});
    push({tag, "_state"}, {30'd0, s});
    #1;
    chk({28'd0, pc_stall, ifid_stall, idex_bubble, ifid_flush});
    chk({30'd0, ctrl_state});
    @(negedge clk);
  endtask

  task automatic cnts(input string tag, input logic [15:0] sc, input logic [15:0] fc);
    push({tag, "_stall_cycles"}, {16'd0, sc});
    push({tag, "_flush_count"}, {16'd0, fc});
    chk({16'd0, stall_cycles});
    chk({16'd0, flush_count});
  endtask

  initial begin
    drv(ADD, 1, 5, 1, 1, 0, 0, 1, 0);
    #1;
    step("reset", 4'b0000, 2'b00);
    cnts("reset", 0, 0);
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 4'b0000, 2'b00);
    // dependency on EX then MEM producer (non-load)
    drv(ADDI, 1, 5, 1, 0, 0, 0, 0, 0);
    step("raw_ex", FWD ? 4'b0000 : 4'b1110, 2'b00);
    drv(ADDI, 1, 0, 0, 0, 5, 1, 0, 0);
    step("raw_mem", FWD ? 4'b0000 : 4'b1110, FWD ? 2'b00 : 2'b01);
    drv(ADDI, 1, 0, 0, 0, 0, 0, 0, 0);
    step("raw_done", 4'b0000, FWD ? 2'b00 : 2'b01);
    step("raw_run", 4'b0000, 2'b00);
    cnts("raw", FWD ? 16'd0 : 16'd2, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr1", 4'b0000, 2'b00);
    cnts("clr1", 0, 0);
    // load-use stalls in both builds
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 0);
    step("lu", 4'b1110, 2'b00);
    drv(ADD, 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rel", 4'b0000, 2'b01);
    step("lu_run", 4'b0000, 2'b00);
    cnts("lu", 1, 0);
    // sources not used, x0 sources, bubbles
    drv(LUI, 1, 5, 1, 1, 5, 1, 0, 0);
    step("lui", 4'b0000, 2'b00);
    drv(ADX0, 1, 0, 1, 1, 0, 1, 0, 0);
    step("x0", 4'b0000, 2'b00);
    drv(ADD, 0, 5, 1, 1, 5, 1, 0, 0);
    step("bubble", 4'b0000, 2'b00);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr2", 4'b0000, 2'b00);
    // redirect during STALL
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 0);
    step("rd_stall", 4'b1110, 2'b00);
    drv(ADD, 1, 5, 1, 1, 0, 0, 1, 0);
    step("rd_hit", 4'b0011, 2'b01);
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 0);
    step("rd_mask", 4'b0000, 2'b10);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rd_run", 4'b0000, 2'b00);
    cnts("rd", 1, 1);
    // back-to-back redirects keep FLUSH
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rr1", 4'b0011, 2'b00);
    step("rr2", 4'b0011, 2'b10);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rr3", 4'b0000, 2'b10);
    step("rr4", 4'b0000, 2'b00);
    cnts("rr", 1, 3);
    // asynchronous reset mid-STALL
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 0);
    step("ar_stall", 4'b1110, 2'b00);
    #2 rst_n = 1'b0;
    step("ar", 4'b0000, 2'b00);
    cnts("ar", 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("ar_rel", 4'b0000, 2'b00);
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 0);
    step("ar_resume", 4'b1110, 2'b00);
    // saturation of stall_cycles, then clear with a stall pending
    drv(ADD, 1, 5, 1, 1, 0, 0, 0, 1);
    step("sat_clr", 4'b1110, 2'b01);
    cnts("sat_clr", 0, 0);
    cnt_clr = 1'b0;
    repeat (65535) @(negedge clk);
    cnts("sat_max", 16'hFFFF, 0);
    step("sat_hold", 4'b1110, 2'b01);
    cnts("sat_hold", 16'hFFFF, 0);
    cnt_clr = 1'b1;
    step("sat_clr2", 4'b1110, 2'b01);
    cnts("sat_clr2", 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising edge.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: id_instr  in  32  instruction held in the IF/ID register.
REQ-004 SHALL: id_valid  in  1  id_instr is a real instruction (0 = bubble).
REQ-005 SHALL: ex_rd, mem_rd  in  5 each  destination register in the EX and MEM stages.
REQ-006 SHALL: ex_regwrite, mem_regwrite  in  1 each  the stage writes its rd.
REQ-007 SHALL: ex_memread  in  1  the EX-stage instruction is a load.
REQ-008 SHALL: ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
REQ-009 SHALL: cnt_clr  in  1  synchronous clear of both counters.
REQ-010 SHALL: pc_stall, ifid_stall  out  1 each  hold PC and hold IF/ID.
REQ-011 SHALL: idex_bubble  out  1  load a NOP into ID/EX.
REQ-012 SHALL: ifid_flush  out  1  load a NOP into IF/ID.
REQ-013 SHALL: ctrl_state  out  2  RUN=00, STALL=01, FLUSH=10.
REQ-014 SHALL: stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-015 SHALL decode opcode id_instr[6:0]:
- 0110011, 0100011, 1100011 use rs1 and rs2.
- 0000011, 0010011, 1100111 use rs1 only.
- 0110111, 0010111, 1101111 and all other opcodes use neither.
REQ-016 SHALL take rs1 from id_instr[19:15] and rs2 from id_instr[24:20]; a source equal to x0 SHALL never match.
REQ-017 SHALL define the raw hazard as: id_valid, state not FLUSH, and a used nonzero source matches a hazard producer (see REQ-027).
REQ-018 SHALL resolve a redirect when ex_redirect=1 in any state: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0, next state FLUSH. A redirect overrides any hazard.
REQ-019 SHALL, when there is a hazard and no redirect, drive pc_stall=ifid_stall=idex_bubble=1 and ifid_flush=0 in the same cycle (Mealy); next state STALL.
REQ-020 SHALL, with no hazard and no redirect, drive all four control outputs 0; next state RUN.
REQ-021 SHALL hold FLUSH for exactly one cycle, with hazard detection masked; it then returns to RUN unless ex_redirect=1 again.
REQ-022 SHALL leave STALL on the first cycle without a hazard, with no stall cap.
REQ-023 SHALL increment stall_cycles on every cycle pc_stall=1, saturating at 0xFFFF.
REQ-024 SHALL increment flush_count on every cycle ifid_flush=1, saturating at 0xFFFF.
REQ-025 SHALL give cnt_clr priority over increments: both counters read 0 the cycle after cnt_clr.

Reset
REQ-026 SHALL, while rst_n=0, set state RUN and both counters 0, and force pc_stall, ifid_stall, idex_bubble and ifid_flush to 0 asynchronously. This includes a reset asserted mid-STALL or mid-FLUSH. The block SHALL resume in RUN on the first edge after release.

Configuration
REQ-027 SHALL use macro HAZARD_FWD_EN to select the hazard producers:
- Defined: forwarding exists; only ex_memread & ex_regwrite & ex_rd match is a hazard (load-use, at most 1 stall cycle).
- Undefined: any ex_regwrite & ex_rd match or mem_regwrite & mem_rd match is a hazard (up to 2 stall cycles). The register file is write-before-read, so WB is never a hazard.

Verification
REQ-028 SHALL cover: FWD_EN defined; ex_memread=1, ex_regwrite=1, ex_rd=5, id_instr=0x006283B3 (add x7,x5,x6) -> pc_stall=idex_bubble=1 for 1 cycle, ctrl_state=01, then RUN; stall_cycles=1.
REQ-029 SHALL cover: FWD_EN undefined; id_instr=0x00128093 (addi x1,x5,1), ex_rd=5 with ex_regwrite=1, then mem_rd=5 next cycle -> 2 stall cycles. With FWD_EN defined and no load -> 0 stall cycles.
REQ-030 SHALL cover: ex_memread=1, ex_rd=5, id_instr=0x000282B7 (lui x5,0x28; field [19:15]=5) -> no stall. Same case with ex_rd=0 and a source of x0 -> no stall.
REQ-031 SHALL cover: ex_redirect=1 during STALL -> same cycle ifid_flush=1, idex_bubble=1, pc_stall=0. Next cycle ctrl_state=10, then 00; flush_count=1.
REQ-032 SHALL cover: rst_n dropped mid-STALL, off the clock edge -> outputs 0 immediately, ctrl_state=00, counters 0. Also: stall_cycles at 0xFFFF with another stall -> stays 0xFFFF; cnt_clr -> 0.
